flit_sender: RTL and testbench

FLIT_SENDER -- requirements
Module: flit_sender

---
 rtl/flit_sender.sv | 87 ++++++++
 tb/tb_flit_sender.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/flit_sender.sv
// Credit-based flit sender feeding a downstream circular buffer of BUFFER_SIZE slots.
// Optional credit-overflow detection on err_o when FLIT_SENDER_CREDIT_CHECK_EN is defined.
module flit_sender #(
    parameter int BUFFER_SIZE = 8,
    parameter int FLIT_SIZE   = 16,
    localparam int CNT_W      = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_SIZE-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [FLIT_SIZE-1:0] flit_o,
    output logic                 flit_valid_o,
    input  logic                 credit_i,
    output logic [CNT_W-1:0]     credits_o,
    output logic                 err_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_SIZE);

    state_t               state;
    logic [FLIT_SIZE-1:0] hold;
    logic                 has_credit;
    logic                 send;

    assign ready_o = (state == IDLE);

    // Send decision looks only at the registered count; a same-cycle credit_i helps next cycle.
    always_comb begin
        has_credit = (credits_o != '0);
        send       = has_credit && ((state == WAIT) || valid_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credits_o    <= FULL;
            flit_valid_o <= 1'b0;
            flit_o       <= '0;
            hold         <= '0;
        end else begin
            flit_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (has_credit) begin
                            flit_o       <= data_i;
                            flit_valid_o <= 1'b1;
                        end else begin
                            hold  <= data_i;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (has_credit) begin
                        flit_o       <= hold;
                        flit_valid_o <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Simultaneous send and credit cancel; a returned credit at full count saturates.
            if (send && !credit_i)
                credits_o <= credits_o - 1'b1;
            else if (!send && credit_i && (credits_o != FULL))
                credits_o <= credits_o + 1'b1;
        end
    end

`ifdef FLIT_SENDER_CREDIT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_o <= 1'b0;
        else if (credit_i && !send && (credits_o == FULL))
            err_o <= 1'b1;
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_flit_sender.sv
// Scoreboard bench for flit_sender (BUFFER_SIZE=4, FLIT_SIZE=16): directed vectors plus a random run.
module tb_flit_sender;

    localparam int BS = 4;
    localparam int FS = 16;
    localparam int CW = $clog2(BS + 1);
`ifdef FLIT_SENDER_CREDIT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [FS-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [FS-1:0] flit_o;
    logic          flit_valid_o;
    logic          credit_i;
    logic [CW-1:0] credits_o;
    logic          err_o;

    flit_sender #(.BUFFER_SIZE(BS), .FLIT_SIZE(FS)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .flit_o(flit_o), .flit_valid_o(flit_valid_o), .credit_i(credit_i),
        .credits_o(credits_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [FS-1:0] sb[$];
    int            outstanding = 0;
    logic [FS-1:0] last_flit = '0;
    logic          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Accepted flits enter the scoreboard; credits returned shrink the downstream occupancy.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            outstanding = 0;
            last_flit   = '0;
        end else begin
            if (valid_i && ready_o) sb.push_back(data_i);
            if (credit_i) outstanding--;
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (flit_valid_o) begin
                outstanding++;
                check("credit_window", 32'(outstanding <= BS), 32'd1);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got %0h expected no strobe at %0t", flit_o, $time);
                end else begin
                    last_flit = sb.pop_front();
                    check("flit_order", 32'(flit_o), 32'(last_flit));
                end
            end else begin
                check("flit_hold", 32'(flit_o), 32'(last_flit));
            end
        end
    end

    initial begin
        logic acc;
        rst = 1'b1; valid_i = 1'b0; credit_i = 1'b0; data_i = '0;
        tick(2);
        mon_en = 1'b1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_credits", 32'(credits_o), 32'd4);
        check("rst_strobe", 32'(flit_valid_o), 32'd0);
        check("rst_flit", 32'(flit_o), 32'h0);
        check("rst_err", 32'(err_o), 32'd0);

        // Four back-to-back transfers drain all credits, first one right after reset.
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            valid_i = 1'b1;
            data_i  = 16'hA000 + 16'(i);
            tick(1);
            check("b2b_strobe", 32'(flit_valid_o), 32'd1);
            check("b2b_flit", 32'(flit_o), 32'hA000 + 32'(i));
            check("b2b_credits", 32'(credits_o), 32'(4 - i));
            check("b2b_ready", 32'(ready_o), 32'd1);
        end
        valid_i = 1'b0;

        // No credits: flit parked in WAIT until a credit arrives.
        valid_i = 1'b1; data_i = 16'hBEEF;
        tick(1);
        check("wait_ready", 32'(ready_o), 32'd0);
        check("wait_strobe", 32'(flit_valid_o), 32'd0);
        credit_i = 1'b1;
        tick(1);
        credit_i = 1'b0;
        check("wait_credit_t1", 32'(credits_o), 32'd1);
        check("wait_no_strobe_t1", 32'(flit_valid_o), 32'd0);
        check("wait_ready_t1", 32'(ready_o), 32'd0);
        tick(1);
        valid_i = 1'b0;
        check("wait_strobe_t2", 32'(flit_valid_o), 32'd1);
        check("wait_flit_t2", 32'(flit_o), 32'hBEEF);
        check("wait_credits_t2", 32'(credits_o), 32'd0);
        check("wait_ready_t2", 32'(ready_o), 32'd1);
        tick(1);
        check("idle_no_strobe", 32'(flit_valid_o), 32'd0);
        check("idle_flit_held", 32'(flit_o), 32'hBEEF);

        // Send and credit in the same cycle leave the count unchanged.
        credit_i = 1'b1;
        tick(2);
        check("credits_two", 32'(credits_o), 32'd2);
        valid_i = 1'b1; data_i = 16'hC001;
        tick(1);
        valid_i = 1'b0; credit_i = 1'b0;
        check("simul_strobe", 32'(flit_valid_o), 32'd1);
        check("simul_flit", 32'(flit_o), 32'hC001);
        check("simul_credits", 32'(credits_o), 32'd2);

        // Overflow credit at full count saturates and optionally flags err_o.
        credit_i = 1'b1;
        tick(2);
        check("credits_full", 32'(credits_o), 32'd4);
        check("err_before_ovf", 32'(err_o), 32'd0);
        tick(1);
        credit_i = 1'b0;
        check("ovf_credits", 32'(credits_o), 32'd4);
        check("ovf_err", 32'(err_o), 32'(EXP_ERR));
        tick(3);
        check("ovf_credits_hold", 32'(credits_o), 32'd4);
        check("ovf_err_sticky", 32'(err_o), 32'(EXP_ERR));

        // Drain credits, park 0x1234 in WAIT, then reset discards it.
        for (int i = 1; i <= 4; i++) begin
            valid_i = 1'b1; data_i = 16'hD000 + 16'(i);
            tick(1);
        end
        data_i = 16'h1234;
        tick(1);
        check("park_ready", 32'(ready_o), 32'd0);
        check("park_credits", 32'(credits_o), 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; valid_i = 1'b0;
        check("rst2_ready", 32'(ready_o), 32'd1);
        check("rst2_credits", 32'(credits_o), 32'd4);
        check("rst2_err", 32'(err_o), 32'd0);
        check("rst2_flit", 32'(flit_o), 32'h0);
        credit_i = 1'b1;
        tick(4);
        credit_i = 1'b0;
        tick(2);
        check("discard_credits", 32'(credits_o), 32'd4);
        check("discard_ready", 32'(ready_o), 32'd1);
        check("discard_no_strobe", 32'(flit_valid_o), 32'd0);

        // Random traffic with a well-behaved downstream.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!valid_i || acc) begin
                valid_i = ($urandom_range(0, 2) != 0);
                data_i  = 16'($urandom);
            end
            credit_i = (outstanding > 0) && ($urandom_range(0, 2) == 0);
            acc = valid_i && ready_o;
            tick(1);
        end
        valid_i = 1'b0;
        for (int c = 0; c < 300 && (sb.size() > 0 || outstanding > 0); c++) begin
            credit_i = (outstanding > 0);
            tick(1);
        end
        credit_i = 1'b0;
        tick(2);
        check("rand_drained", 32'(sb.size()), 32'd0);
        check("rand_credits", 32'(credits_o), 32'd4);
        check("rand_ready", 32'(ready_o), 32'd1);
        check("rand_err", 32'(err_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
